// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline latch with branch/jump resolution.
// Takes the ALU result plus control for the instruction in EX, resolves
// conditional branches from the Rs flags, issues a one-cycle fetch redirect
// and then turns the next SQUASH_SLOTS valid EX slots into bubbles.
// A MEM-side stall freezes everything except the redirect pulse.
module ex_mem_stage #(
  parameter int unsigned SQUASH_SLOTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] alu_out,
  input  logic        alu_msb,
  input  logic        alu_zero,
  input  logic [2:0]  br_type,
  input  logic [15:0] br_target,
  input  logic [15:0] pc_plus2,
  input  logic        link,
  input  logic [2:0]  rd,
  input  logic        reg_we,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [15:0] store_data,
  input  logic        stall,
  output logic        ex_ready,
  output logic        m_valid,
  output logic [15:0] m_result,
  output logic [2:0]  m_rd,
  output logic        m_reg_we,
  output logic        m_mem_re,
  output logic        m_mem_we,
  output logic [15:0] m_store_data,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic        squashing
);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  localparam logic [2:0] BR_BEQZ = 3'b001;
  localparam logic [2:0] BR_BNEZ = 3'b010;
  localparam logic [2:0] BR_BLTZ = 3'b011;
  localparam logic [2:0] BR_BGEZ = 3'b100;
  localparam logic [2:0] BR_J    = 3'b101;
  localparam logic [2:0] BR_JR   = 3'b110;

  // Counter reload; valid range 1..7 fits in three bits.
  localparam logic [2:0] SLOTS = 3'(SQUASH_SLOTS);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        m_valid_q;
  logic [15:0] m_result_q;
  logic [2:0]  m_rd_q;
  logic        m_reg_we_q;
  logic        m_mem_re_q;
  logic        m_mem_we_q;
  logic [15:0] m_store_data_q;
  logic        redirect_q;
  logic [15:0] redirect_pc_q;

  logic        taken_d;
  logic [15:0] target_d;
  logic [15:0] result_d;

  // Branch decision and target selection for the instruction sitting in EX.
  always_comb begin
    taken_d  = 1'b0;
    target_d = br_target;
    case (br_type)
      BR_BEQZ: taken_d = alu_zero;
      BR_BNEZ: taken_d = ~alu_zero;
      BR_BLTZ: taken_d = alu_msb;
      BR_BGEZ: taken_d = ~alu_msb;
      BR_J:    taken_d = 1'b1;
      BR_JR: begin
        taken_d  = 1'b1;
        target_d = alu_out;
      end
      default: taken_d = 1'b0;
    endcase
    // Instructions are halfword aligned, so the target LSB is never set.
    target_d[0] = 1'b0;
    // Linking jumps write their return address instead of the ALU value.
    result_d = link ? pc_plus2 : alu_out;
  end

  // Latch, resolve/squash FSM and redirect pulse; stall freezes all but redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_NORMAL;
      cnt_q          <= 3'd0;
      m_valid_q      <= 1'b0;
      m_result_q     <= 16'h0000;
      m_rd_q         <= 3'd0;
      m_reg_we_q     <= 1'b0;
      m_mem_re_q     <= 1'b0;
      m_mem_we_q     <= 1'b0;
      m_store_data_q <= 16'h0000;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= 16'h0000;
    end else begin
      // The redirect is a pulse: it drops on the next edge even under stall.
      redirect_q <= 1'b0;
      if (!stall) begin
        case (state_q)
          ST_NORMAL: begin
            if (ex_valid) begin
              m_valid_q      <= 1'b1;
              m_result_q     <= result_d;
              m_rd_q         <= rd;
              m_reg_we_q     <= reg_we;
              m_mem_re_q     <= mem_re;
              m_mem_we_q     <= mem_we;
              m_store_data_q <= store_data;
              if (taken_d) begin
                redirect_q    <= 1'b1;
                redirect_pc_q <= target_d;
                state_q       <= ST_SQUASH;
                cnt_q         <= SLOTS;
              end
            end else begin
              // Bubble: data fields keep their last value, controls go quiet.
              m_valid_q  <= 1'b0;
              m_reg_we_q <= 1'b0;
              m_mem_re_q <= 1'b0;
              m_mem_we_q <= 1'b0;
            end
          end
          ST_SQUASH: begin
            // Wrong-path slot: drop it, and only count slots that held work.
            m_valid_q  <= 1'b0;
            m_reg_we_q <= 1'b0;
            m_mem_re_q <= 1'b0;
            m_mem_we_q <= 1'b0;
            if (ex_valid) begin
              cnt_q <= cnt_q - 3'd1;
              if (cnt_q == 3'd1) state_q <= ST_NORMAL;
            end
          end
          default: begin
            state_q <= ST_NORMAL;
            cnt_q   <= 3'd0;
          end
        endcase
      end
    end
  end

  assign ex_ready     = ~stall;
  assign m_valid      = m_valid_q;
  assign m_result     = m_result_q;
  assign m_rd         = m_rd_q;
  assign m_reg_we     = m_reg_we_q;
  assign m_mem_re     = m_mem_re_q;
  assign m_mem_we     = m_mem_we_q;
  assign m_store_data = m_store_data_q;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign squashing    = (state_q == ST_SQUASH);

endmodule
